dtree_rr_sched: RTL and testbench
=================================

Name: dtree_rr_sched

Overview:
- Round-robin scheduler that time-shares one combinational decision-tree classifier core (feature in, class code out) among NREQ requesters.
- Per requester it accepts a feature word through a valid/ready handshake and drives the feature into the shared core from a register.
- Waits CORE_LAT cycles for the printed-logic core to settle, then returns the class with the requester id through a valid/ready response port.
- Sits between the sensor-sample front ends and the tree core.

Parameters:
- NREQ, 4, number of requesters (1..16)
- FEAT_W, 8, feature width
- CLS_W, 4, class code width
- CORE_LAT, 1, settle cycles allowed for the core (1..7)
- ID_W, clog2(NREQ) (min 1), response id width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_feat  in  NREQ*FEAT_W  requester i feature at bits [i*FEAT_W +: FEAT_W]
- req_ready  out  NREQ  one-hot grant/accept
- core_x  out  FEAT_W  registered feature to the tree core
- core_out  in  CLS_W  class code from the tree core
- rsp_valid  out  1  response valid
- rsp_id  out  ID_W  index of the served requester
- rsp_class  out  CLS_W  captured class
- rsp_ready  in  1  response sink ready
- busy  out  1  high in EVAL or RESP

Behaviour:
- Reset (async, any state, including mid-EVAL or mid-RESP):
  - state=IDLE, ptr=0, cnt=0.
  - core_x=0, rsp_valid=0, rsp_id=0, rsp_class=0, req_ready=0, busy=0.
  - In-flight request is dropped.
- IDLE:
  - If any req_valid is high, grant g = first i with req_valid[i]=1, scanning ptr, ptr+1, ... mod NREQ.
  - req_ready[g]=1 combinationally in this cycle only; all other bits are 0.
  - At the edge: core_x<=req_feat[g], rsp_id<=g, ptr<=(g+1) mod NREQ, cnt<=CORE_LAT-1, state<=EVAL.
  - If no req_valid is high, remain in IDLE.
- EVAL:
  - req_ready=0.
  - If cnt!=0, cnt decrements.
  - If cnt==0, at the edge rsp_class<=core_out and state<=RESP.
  - EVAL therefore lasts exactly CORE_LAT cycles.
- RESP:
  - rsp_valid=1; rsp_id and rsp_class held stable.
  - When rsp_ready=1, at the edge rsp_valid<=0 and state<=IDLE.
  - While rsp_ready=0, hold indefinitely; no grants are issued.
- Latency:
  - rsp_valid rises CORE_LAT edges after the request handshake edge.
  - With rsp_ready tied high, back-to-back service period is CORE_LAT+2 cycles.
- core_x changes only on a grant edge or reset; it holds its value between grants.
- rsp_id and rsp_class hold their last values after the response handshake.
- req_valid may drop without being granted; it is not required to be sticky.
- A requester that drops req_valid after its grant does not affect the in-flight evaluation.
- NREQ=1: ptr is stuck at 0; behaviour is otherwise identical.
- Pointer wrap: grant to NREQ-1 sets ptr=0.
- Synthesis-time error if CORE_LAT<1 or CORE_LAT>7.

Optional Feature:
- Macro: DTREE_SCHED_OVERLAP_EN.
- Defined:
  - In RESP with rsp_ready=1 and any req_valid high, the next grant is issued in the same cycle, using the same round-robin rule and the same req_ready pulse.
  - State goes directly RESP->EVAL at that edge; core_x and rsp_id are loaded at that edge.
  - rsp_class keeps its value until the next EVAL capture.
  - Back-to-back period becomes CORE_LAT+1.
- Not defined: RESP always returns to IDLE, and the period is CORE_LAT+2.

Test Plan:
- Reset mid-op:
  - Stimulus: NREQ=4, CORE_LAT=3; assert rst during the 2nd EVAL cycle.
  - Required: next cycle rsp_valid=0, busy=0, core_x=0, req_ready=0.
  - Required: with all req_valid=1 after release, the first grant is req_ready=4'b0001.
- Single request:
  - Stimulus: CORE_LAT=1, req_valid=4'b0100, feature 2 = 0x9C; core model drives class 0xC for 0x9C.
  - Required: req_ready=4'b0100 for 1 cycle, core_x=0x9C.
  - Required: rsp_valid high 1 edge later with rsp_id=2, rsp_class=0xC.
- Fairness:
  - Stimulus: all req_valid=1, rsp_ready=1, CORE_LAT=1.
  - Required: grants 0,1,2,3,0 spaced exactly 3 cycles apart; busy low only in grant cycles.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles in RESP.
  - Required: rsp_valid, rsp_id, rsp_class stable; req_ready=0 throughout.
  - Required: after rsp_ready=1, return to IDLE on the next edge.
- Pointer skip:
  - Stimulus: after a grant to 1, only req_valid[0] and req_valid[3] are high.
  - Required: grant 3, then 0, then 3.
- Overlap (DTREE_SCHED_OVERLAP_EN, CORE_LAT=1):
  - Stimulus: all req_valid=1, rsp_ready=1.
  - Required: grants every 2 cycles.
  - Required: each req_ready pulse coincides with a rsp_valid&rsp_ready cycle after the first.

Source files
------------

// File: rtl/dtree_rr_sched.sv
// -----------------------------------------------------------------------------
// dtree_rr_sched
//
// Round-robin scheduler that time-shares one combinational decision-tree
// classifier core among NREQ requesters. A granted feature word is registered
// onto core_x. The core is given CORE_LAT cycles to settle, then its class code
// is captured and returned together with the requester id.
//
// Optional feature macro: DTREE_SCHED_OVERLAP_EN
//   When defined, a response handshake and the next grant can share one cycle,
//   so RESP goes straight to EVAL and the back-to-back period drops from
//   CORE_LAT+2 to CORE_LAT+1 cycles.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is a one-cycle one-hot grant and depends
// combinationally on req_valid. rsp_valid stays high, with rsp_id and
// rsp_class stable, until rsp_ready is seen high.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   [NREQ]         per-requester request valid
//   req_feat   in   [NREQ*FEAT_W]  requester i feature at [i*FEAT_W +: FEAT_W]
//   req_ready  out  [NREQ]         one-hot grant/accept
//   core_x     out  [FEAT_W]       registered feature to the tree core
//   core_out   in   [CLS_W]        class code from the tree core
//   rsp_valid  out                 response valid
//   rsp_id     out  [ID_W]         index of the served requester
//   rsp_class  out  [CLS_W]        captured class
//   rsp_ready  in                  response sink ready
//   busy       out                 high in EVAL or RESP
//   dbg_state  out  [2]            FSM state (0=IDLE, 1=EVAL, 2=RESP)
// -----------------------------------------------------------------------------
module dtree_rr_sched #(
  parameter int NREQ     = 4,
  parameter int FEAT_W   = 8,
  parameter int CLS_W    = 4,
  parameter int CORE_LAT = 1,
  parameter int ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*FEAT_W-1:0]   req_feat,
  output logic [NREQ-1:0]          req_ready,
  output logic [FEAT_W-1:0]        core_x,
  input  logic [CLS_W-1:0]         core_out,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [CLS_W-1:0]         rsp_class,
  input  logic                     rsp_ready,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  generate
    if (CORE_LAT < 1 || CORE_LAT > 7) begin : g_bad_core_lat
      $error("dtree_rr_sched: CORE_LAT must be in 1..7");
    end
    if (NREQ < 1 || NREQ > 16) begin : g_bad_nreq
      $error("dtree_rr_sched: NREQ must be in 1..16");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [2:0]        r_cnt;
  logic [FEAT_W-1:0] r_core_x;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [CLS_W-1:0]  r_rsp_class;

  logic              w_found;
  logic [ID_W-1:0]   w_gnt_id;
  logic [31:0]       w_idx;
  logic [NREQ-1:0]   w_onehot;
  logic [FEAT_W-1:0] w_gnt_feat;
  logic              w_grant;
  logic [ID_W-1:0]   w_ptr_next;

  // Round-robin search: first valid requester at or after r_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = (32'(r_ptr) + 32'(i)) % 32'(NREQ);
      if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = w_idx[ID_W-1:0];
      end
    end
  end

  // Feature mux and one-hot decode of the winning index.
  always_comb begin
    w_gnt_feat = '0;
    w_onehot   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_gnt_id == ID_W'(j)) begin
        w_gnt_feat  = req_feat[j*FEAT_W +: FEAT_W];
        w_onehot[j] = 1'b1;
      end
    end
  end

`ifdef DTREE_SCHED_OVERLAP_EN
  // A grant may also be issued in the cycle the response is consumed.
  assign w_grant = w_found &&
                   ((r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready));
`else
  assign w_grant = w_found && (r_state == ST_IDLE);
`endif

  assign w_ptr_next = (w_gnt_id == ID_W'(NREQ - 1)) ? '0 : (w_gnt_id + 1'b1);

  // Gated by rst so no grant is advertised while reset is held.
  assign req_ready = (w_grant && !rst) ? w_onehot : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_core_x    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_class <= '0;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_EVAL: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_rsp_class <= core_out;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Grant load; w_grant is only ever true in IDLE or in a consumed RESP,
      // so this overrides the RESP->IDLE move when the cycles overlap.
      if (w_grant) begin
        r_core_x <= w_gnt_feat;
        r_rsp_id <= w_gnt_id;
        r_ptr    <= w_ptr_next;
        r_cnt    <= 3'(CORE_LAT - 1);
        r_state  <= ST_EVAL;
      end
    end
  end

  assign core_x    = r_core_x;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_class = r_rsp_class;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dtree_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_dtree_rr_sched
//
// Bench for dtree_rr_sched. u_dut (CORE_LAT=1) covers grants, fairness,
// backpressure and pointer skipping. u_dut_b (CORE_LAT=3) covers reset in the
// middle of an evaluation. The tree core is modelled by tree_cls().
// -----------------------------------------------------------------------------
module tb_dtree_rr_sched;

  localparam int NREQ   = 4;
  localparam int FEAT_W = 8;
  localparam int CLS_W  = 4;
  localparam int ID_W   = 2;
  localparam int LAT_A  = 1;
  localparam int LAT_B  = 3;
`ifdef DTREE_SCHED_OVERLAP_EN
  localparam int PER = LAT_A + 1;
  localparam bit OVL = 1'b1;
`else
  localparam int PER = LAT_A + 2;
  localparam bit OVL = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic rst_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A signals ----------------
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*FEAT_W-1:0] req_feat;
  logic [NREQ-1:0]        req_ready;
  logic [FEAT_W-1:0]      core_x;
  logic [CLS_W-1:0]       core_out;
  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [CLS_W-1:0]       rsp_class;
  logic                   rsp_ready;
  logic                   busy;
  logic [1:0]             dbg_state;

  // ---------------- DUT B signals ----------------
  logic [NREQ-1:0]        b_req_valid;
  logic [NREQ*FEAT_W-1:0] b_req_feat;
  logic [NREQ-1:0]        b_req_ready;
  logic [FEAT_W-1:0]      b_core_x;
  logic [CLS_W-1:0]       b_core_out;
  logic                   b_rsp_valid;
  logic [ID_W-1:0]        b_rsp_id;
  logic [CLS_W-1:0]       b_rsp_class;
  logic                   b_rsp_ready;
  logic                   b_busy;
  logic [1:0]             b_dbg_state;

  // Small decision tree: bit 7 selects between the low nibble and a
  // scrambled high nibble.
  function automatic logic [3:0] tree_cls(input logic [7:0] x);
    return x[7] ? x[3:0] : (x[7:4] ^ 4'h5);
  endfunction

  assign core_out   = tree_cls(core_x);
  assign b_core_out = tree_cls(b_core_x);

  dtree_rr_sched #(
    .NREQ(NREQ), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .CORE_LAT(LAT_A), .ID_W(ID_W)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_feat(req_feat), .req_ready(req_ready),
    .core_x(core_x), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_class(rsp_class),
    .rsp_ready(rsp_ready), .busy(busy), .dbg_state(dbg_state)
  );

  dtree_rr_sched #(
    .NREQ(NREQ), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .CORE_LAT(LAT_B), .ID_W(ID_W)
  ) u_dut_b (
    .clk(clk), .rst(rst_b),
    .req_valid(b_req_valid), .req_feat(b_req_feat), .req_ready(b_req_ready),
    .core_x(b_core_x), .core_out(b_core_out),
    .rsp_valid(b_rsp_valid), .rsp_id(b_rsp_id), .rsp_class(b_rsp_class),
    .rsp_ready(b_rsp_ready), .busy(b_busy), .dbg_state(b_dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [ID_W+CLS_W-1:0] exp_q[$];
  logic [ID_W+CLS_W-1:0] sb_e;

  // Inputs change at the falling edge; responses are taken 2 time units later.
  always @(negedge clk) begin
    #2;
    if (rsp_valid && rsp_ready) begin
      chk("sb_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        sb_e = exp_q.pop_front();
        chk("sb_rsp_id", 32'(rsp_id), 32'(sb_e[ID_W+CLS_W-1:CLS_W]));
        chk("sb_rsp_class", 32'(rsp_class), 32'(sb_e[CLS_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Starts from IDLE. Grant k is expected at cycle k*PER; gseq nibble k is
  // the requester expected to win it.
  task automatic run_grants(input logic [3:0] v_first, input logic [3:0] v_rest,
                            input int n, input logic [31:0] gseq);
    logic [3:0] g;
    logic [3:0] exp_rdy;
    logic       gc;
    for (int c = 0; c <= (n - 1) * PER; c++) begin
      @(negedge clk);
      req_valid = (c == 0) ? v_first : v_rest;
      #1;
      gc      = ((c % PER) == 0);
      g       = gseq[4*(c/PER) +: 4];
      exp_rdy = gc ? (4'b0001 << g) : 4'b0000;
      chk("rr_req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rr_busy", 32'(busy), 32'((!gc) || (OVL && c != 0)));
      if (gc) begin
        chk("rr_rsp_valid_at_grant", 32'(rsp_valid), 32'(OVL && c != 0));
        exp_q.push_back({g[ID_W-1:0], tree_cls(req_feat[g*FEAT_W +: FEAT_W])});
      end
      if ((c % PER) == 1) begin
        chk("rr_core_x", 32'(core_x), 32'(req_feat[g*FEAT_W +: FEAT_W]));
      end
    end
    @(negedge clk);
    req_valid = '0;
    repeat (LAT_A + 1) @(negedge clk);
    #1;
    chk("rr_drain_busy", 32'(busy), 32'd0);
    chk("rr_drain_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    rst_b       = 1'b1;
    req_valid   = 4'hF;
    req_feat    = '0;
    rsp_ready   = 1'b1;
    b_req_valid = '0;
    b_req_feat  = '0;
    b_rsp_ready = 1'b1;

    // Reset state, with requests pending to show req_ready is held low.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_x", 32'(core_x), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_class", 32'(rsp_class), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_dbg_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    rst_b     = 1'b0;
    req_valid = '0;

    // Reset in the middle of EVAL on the CORE_LAT=3 instance.
    @(negedge clk);
    b_req_feat[2*FEAT_W +: FEAT_W] = 8'h5A;
    b_req_valid = 4'b0100;
    #1;
    chk("midrst_grant", 32'(b_req_ready), 32'h4);
    @(negedge clk);
    b_req_valid = '0;
    #1;
    chk("midrst_core_x", 32'(b_core_x), 32'h5A);
    chk("midrst_busy_eval", 32'(b_busy), 32'd1);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    b_req_valid = 4'hF;
    #1;
    chk("midrst_rsp_valid", 32'(b_rsp_valid), 32'd0);
    chk("midrst_busy", 32'(b_busy), 32'd0);
    chk("midrst_core_x_clr", 32'(b_core_x), 32'd0);
    chk("midrst_req_ready", 32'(b_req_ready), 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("midrst_first_grant", 32'(b_req_ready), 32'h1);
    @(negedge clk);
    b_req_valid = '0;

    // Fairness from ptr=0 with everyone requesting.
    for (int i = 0; i < NREQ; i++) begin
      req_feat[i*FEAT_W +: FEAT_W] = 8'($urandom_range(0, 255));
    end
    run_grants(4'hF, 4'hF, 5, 32'h0000_3210);

    // Single request from requester 2 (ptr is 1 here).
    @(negedge clk);
    req_feat[2*FEAT_W +: FEAT_W] = 8'h9C;
    req_valid = 4'b0100;
    #1;
    chk("single_req_ready", 32'(req_ready), 32'h4);
    exp_q.push_back({2'd2, 4'hC});
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("single_req_ready_drop", 32'(req_ready), 32'd0);
    chk("single_core_x", 32'(core_x), 32'h9C);
    chk("single_eval_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("single_eval_busy", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("single_rsp_id", 32'(rsp_id), 32'd2);
    chk("single_rsp_class", 32'(rsp_class), 32'hC);
    @(negedge clk);
    #1;
    chk("single_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("single_idle_busy", 32'(busy), 32'd0);

    // Backpressure (ptr is 3, so requester 0 wins after wrap).
    @(negedge clk);
    req_feat[0 +: FEAT_W] = 8'h3E;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h1);
    exp_q.push_back({2'd0, tree_cls(8'h3E)});
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    chk("bp_eval_req_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_id", 32'(rsp_id), 32'd0);
      chk("bp_rsp_class", 32'(rsp_class), 32'(tree_cls(8'h3E)));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = '0;
    #1;
    chk("bp_release_rsp_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    #1;
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_hold_rsp_id", 32'(rsp_id), 32'd0);
    chk("bp_hold_rsp_class", 32'(rsp_class), 32'(tree_cls(8'h3E)));

    // Pointer skip: grant 1, then only 0 and 3 request -> 3, 0, 3.
    for (int i = 0; i < NREQ; i++) begin
      req_feat[i*FEAT_W +: FEAT_W] = 8'($urandom_range(0, 255));
    end
    run_grants(4'b0010, 4'b1001, 4, 32'h0000_3031);

    repeat (3) @(negedge clk);
    #3;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
